// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - vending machine coin initiator; COIN_FEEDER_STATS_EN enables outcome counters
module coin_feeder #(
  parameter int AMT_W   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             req_pref_one,
  output logic             half,
  output logic             one,
  input  logic             drink,
  input  logic             change,
  output logic             busy,
  output logic             done,
  output logic             done_ok,
  output logic             done_change,
  output logic [AMT_W-1:0] done_left,
  output logic [15:0]      vend_count,
  output logic [15:0]      timeout_count
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INSERT,
    GAPS,
    WAIT_VEND,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [AMT_W-1:0] remaining;
  logic             pref;
  logic             seen_drink, seen_change;
  logic [GW-1:0]    gap_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             held_ok, held_change;
  logic [AMT_W-1:0] held_left;
  logic             drink_any;
  logic             observing;

  assign drink_any = seen_drink | drink;
  assign observing = (state == INSERT) || (state == GAPS) || (state == WAIT_VEND);

  // Coin choice depends only on registered state, so each pulse is exactly one INSERT cycle.
  assign one  = (state == INSERT) && pref && (remaining >= AMT_W'(2));
  assign half = (state == INSERT) && (remaining != '0) && !one;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign done_ok     = done ? seen_drink  : held_ok;
  assign done_change = done ? seen_change : held_change;
  assign done_left   = done ? remaining   : held_left;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (req_valid) state_n = INSERT;
      INSERT:    state_n = (remaining == '0) ? WAIT_VEND : GAPS;
      GAPS: begin
        // A vend seen during the gap stops further coins but the gap still runs out.
        if (gap_cnt == GW'(GAP - 1))
          state_n = ((remaining != '0) && !drink_any) ? INSERT : WAIT_VEND;
      end
      WAIT_VEND: if (drink_any || (wait_cnt == TW'(TIMEOUT - 1))) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      pref        <= 1'b0;
      seen_drink  <= 1'b0;
      seen_change <= 1'b0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      held_ok     <= 1'b0;
      held_change <= 1'b0;
      held_left   <= '0;
    end else begin
      state    <= state_n;
      gap_cnt  <= (state == GAPS) ? gap_cnt + GW'(1) : '0;
      wait_cnt <= (state == WAIT_VEND) ? wait_cnt + TW'(1) : '0;
      if (observing) begin
        seen_drink  <= seen_drink | drink;
        seen_change <= seen_change | change;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining   <= req_amount;
            pref        <= req_pref_one;
            seen_drink  <= 1'b0;
            seen_change <= 1'b0;
          end
        end
        INSERT: begin
          if (one)       remaining <= remaining - AMT_W'(2);
          else if (half) remaining <= remaining - AMT_W'(1);
        end
        DONE: begin
          held_ok     <= seen_drink;
          held_change <= seen_change;
          held_left   <= remaining;
        end
        default: ;
      endcase
    end
  end

`ifdef COIN_FEEDER_STATS_EN
  logic [15:0] vend_q, timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vend_q    <= '0;
      timeout_q <= '0;
    end else if (state == DONE) begin
      if (seen_drink) begin
        if (vend_q != 16'hFFFF) vend_q <= vend_q + 16'd1;
      end else begin
        if (timeout_q != 16'hFFFF) timeout_q <= timeout_q + 16'd1;
      end
    end
  end

  assign vend_count    = vend_q;
  assign timeout_count = timeout_q;
`else
  assign vend_count    = 16'd0;
  assign timeout_count = 16'd0;
`endif

endmodule

// File: tb/tb_coin_feeder.sv
// tb/tb_coin_feeder.sv - randomized self-checking bench for coin_feeder against a reactive machine model
module tb_coin_feeder;

  localparam int AMT_W   = 4;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_pref_one = 1'b0;
  logic             half, one;
  logic             drink = 1'b0;
  logic             change = 1'b0;
  logic             busy, done, done_ok, done_change;
  logic [AMT_W-1:0] done_left;
  logic [15:0]      vend_count, timeout_count;

  int n_cmp = 0;
  int n_bad = 0;
  int vend_model = 0;
  int timeout_model = 0;

  coin_feeder #(.AMT_W(AMT_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .req_pref_one(req_pref_one),
    .half(half), .one(one),
    .drink(drink), .change(change),
    .busy(busy), .done(done), .done_ok(done_ok), .done_change(done_change),
    .done_left(done_left),
    .vend_count(vend_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters();
`ifdef COIN_FEEDER_STATS_EN
    check_eq("vend_count", vend_count, vend_model);
    check_eq("timeout_count", timeout_count, timeout_model);
`else
    check_eq("vend_count", vend_count, 0);
    check_eq("timeout_count", timeout_count, 0);
`endif
  endtask

  // price==0 means the machine never vends; otherwise it vends (with change if overpaid)
  // the cycle after the accumulated coins reach the price.
  task automatic run_req(input int amt, input bit pref, input int price, input bit keep);
    int plan[$];
    int rem, sum, nsent, sent_sum, exp_left, done_at, tc, wait_n;
    bit exp_ok, exp_chg, got_done;
    int acc;
    bit vended, pd, pc;
    logic [1:0] exp_coin;

    rem = amt;
    while (rem > 0) begin
      if (pref && rem >= 2) begin plan.push_back(2); rem -= 2; end
      else begin plan.push_back(1); rem -= 1; end
    end
    nsent = plan.size(); exp_ok = 0; exp_chg = 0; sum = 0;
    foreach (plan[i]) begin
      sum += plan[i];
      if (price > 0 && sum >= price) begin
        nsent = i + 1; exp_ok = 1; exp_chg = (sum > price); break;
      end
    end
    sent_sum = 0;
    for (int i = 0; i < nsent; i++) sent_sum += plan[i];
    exp_left = amt - sent_sum;
    if (nsent == 0) done_at = 2 + TIMEOUT;
    else begin
      tc = 1 + (nsent - 1) * (GAP + 1);
      done_at = exp_ok ? tc + GAP + 2 : tc + GAP + 1 + TIMEOUT;
    end

    req_valid = 1'b1;
    req_amount = AMT_W'(amt);
    req_pref_one = pref;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin tick(); wait_n++; end
    check_eq("accept_wait", wait_n, 0);
    tick();
    if (!keep) req_valid = 1'b0;

    acc = 0; vended = 0; pd = 0; pc = 0; got_done = 0;
    for (int c = 1; c <= done_at + 1 && !got_done; c++) begin
      if (c > 1) tick();
      drink = pd; change = pc; pd = 0; pc = 0;
      exp_coin = 2'b00;
      if ((c - 1) % (GAP + 1) == 0 && (c - 1) / (GAP + 1) < nsent)
        exp_coin = (plan[(c - 1) / (GAP + 1)] == 2) ? 2'b10 : 2'b01;
      check_eq("coin", {one, half}, exp_coin);
      check_eq("done_timing", done, c == done_at);
      check_eq("busy_ready", {busy, req_ready}, 2'b10);
      if (one || half) acc += one ? 2 : 1;
      if (price > 0 && !vended && acc >= price) begin
        vended = 1; pd = 1; pc = (acc > price);
      end
      if (done) begin
        got_done = 1;
        check_eq("done_ok", done_ok, exp_ok);
        check_eq("done_change", done_change, exp_chg);
        check_eq("done_left", done_left, exp_left);
        if (exp_ok) begin if (vend_model < 65535) vend_model++; end
        else begin if (timeout_model < 65535) timeout_model++; end
      end
    end
    drink = 1'b0; change = 1'b0;
    tick();
    check_eq("idle_ready", {busy, req_ready, done}, 3'b010);
    check_eq("held_ok", done_ok, exp_ok);
    check_eq("held_left", done_left, exp_left);
    check_counters();
  endtask

  task automatic run_reset_mid();
    req_valid = 1'b1; req_amount = AMT_W'(5); req_pref_one = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 2 * (GAP + 1); c++) tick();
    check_eq("pre_rst_gap", {one, half, busy}, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vend_model = 0; timeout_model = 0;
    check_eq("rst_coins", {one, half}, 2'b00);
    check_eq("rst_ready", {busy, req_ready, done}, 3'b010);
    check_eq("rst_left", done_left, 0);
    check_counters();
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      tick();
      check_eq("rst_quiet", {one, half, done, busy}, 4'b0000);
    end
  endtask

  initial begin
    int amt, price;
    bit pref;
    rst = 1'b1;
    tick(); tick();
    check_eq("reset_coins", {one, half}, 2'b00);
    check_eq("reset_hs", {busy, req_ready, done}, 3'b010);
    check_eq("reset_fields", {done_ok, done_change, 4'(done_left)}, 0);
    check_counters();
    rst = 1'b0;

    run_req(5, 1, 5, 0);
    run_req(6, 1, 5, 0);
    run_req(6, 0, 5, 0);
    run_req(2, 1, 0, 0);
    run_req(0, 0, 3, 0);
    run_req(7, 1, 5, 1);
    run_req(4, 0, 0, 0);
    run_reset_mid();

    for (int i = 0; i < 30; i++) begin
      amt = $urandom_range(15, 0);
      pref = 1'($urandom_range(1, 0));
      price = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(15, 1);
      run_req(amt, pref, price, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
